// File: rtl/dca_matrix_register_type3.sv
// rtl/dca_matrix_register_type3.sv - NUM_ROW x NUM_COL matrix register with row-stream load/drain, shifts and transpose
// Ports:
//   clk, rstnn                 clock, asynchronous active-low reset
//   init                       fill with INIT_VALUE, abort any stream
//   load_start/valid/ready/data   row-stream load (first beat ends up in row 0)
//   drain_start/valid/ready/data  row-stream drain (drain_data = row 0)
//   all_wenable/all_wdata_list2d  whole-matrix write
//   shift_up, downmost_*       rows move up, bottom row filled
//   shift_left, rightmost_*    columns move left, right column filled
//   transpose                  in-place transpose (square only)
//   all_rdata_list2d, upmost_rdata_list1d  matrix / row 0 read
//   busy, done                 stream in progress / one-cycle completion pulse
module dca_matrix_register_type3 #(
   parameter int NUM_ROW = 4,
   parameter int NUM_COL = 4,
   parameter int BW_TENSOR_SCALAR = 32,
   parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = '0,
   parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE = RESET_VALUE,
   localparam int BW_ROW = NUM_COL*BW_TENSOR_SCALAR,
   localparam int BW_COLUMN = NUM_ROW*BW_TENSOR_SCALAR,
   localparam int BW_MATRIX = NUM_ROW*BW_ROW
) (
   input  logic                 clk,
   input  logic                 rstnn,
   input  logic                 init,
   input  logic                 load_start,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [BW_ROW-1:0]    load_data,
   input  logic                 drain_start,
   output logic                 drain_valid,
   input  logic                 drain_ready,
   output logic [BW_ROW-1:0]    drain_data,
   input  logic                 all_wenable,
   input  logic [BW_MATRIX-1:0] all_wdata_list2d,
   input  logic                 shift_up,
   input  logic                 downmost_wenable,
   input  logic [BW_ROW-1:0]    downmost_wdata_list1d,
   input  logic                 shift_left,
   input  logic                 rightmost_wenable,
   input  logic [BW_COLUMN-1:0] rightmost_wdata_list1d,
   input  logic                 transpose,
   output logic [BW_MATRIX-1:0] all_rdata_list2d,
   output logic [BW_ROW-1:0]    upmost_rdata_list1d,
   output logic                 busy,
   output logic                 done
);

   localparam int BW = BW_TENSOR_SCALAR;
   localparam int CW = $clog2(NUM_ROW+1);
   localparam logic [BW_MATRIX-1:0] RESET_MATRIX = {NUM_ROW*NUM_COL{RESET_VALUE}};
   localparam logic [BW_MATRIX-1:0] INIT_MATRIX  = {NUM_ROW*NUM_COL{INIT_VALUE}};
   localparam logic [BW_ROW-1:0]    INIT_ROW     = {NUM_COL{INIT_VALUE}};
   localparam logic [BW_COLUMN-1:0] INIT_COLUMN  = {NUM_ROW{INIT_VALUE}};
   localparam logic [CW-1:0]        LAST_BEAT    = CW'(NUM_ROW-1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   state_t               state, state_next;
   logic [CW-1:0]        cnt, cnt_next;
   logic [BW_MATRIX-1:0] mat, mat_next, mat_tr;
   logic                 done_q, done_next;

   // Row r takes row r+1; the new bottom row is fill.
   function automatic logic [BW_MATRIX-1:0] rows_up(input logic [BW_MATRIX-1:0] m,
                                                    input logic [BW_ROW-1:0] fill);
      logic [BW_MATRIX-1:0] o;
      o = m;
      for (int r = 0; r < NUM_ROW-1; r++)
         o[r*BW_ROW +: BW_ROW] = m[(r+1)*BW_ROW +: BW_ROW];
      o[(NUM_ROW-1)*BW_ROW +: BW_ROW] = fill;
      return o;
   endfunction

   // Element (r,c) takes (r,c+1); element r of fill lands in the last column of row r.
   function automatic logic [BW_MATRIX-1:0] cols_left(input logic [BW_MATRIX-1:0] m,
                                                      input logic [BW_COLUMN-1:0] fill);
      logic [BW_MATRIX-1:0] o;
      o = m;
      for (int r = 0; r < NUM_ROW; r++) begin
         for (int c = 0; c < NUM_COL-1; c++)
            o[(r*NUM_COL+c)*BW +: BW] = m[(r*NUM_COL+c+1)*BW +: BW];
         o[(r*NUM_COL+NUM_COL-1)*BW +: BW] = fill[r*BW +: BW];
      end
      return o;
   endfunction

   // Non-square shapes get an identity so a transpose request leaves the matrix untouched.
   generate
      if (NUM_ROW == NUM_COL) begin : g_square
         always_comb begin
            mat_tr = mat;
            for (int r = 0; r < NUM_ROW; r++)
               for (int c = 0; c < NUM_COL; c++)
                  mat_tr[(r*NUM_COL+c)*BW +: BW] = mat[(c*NUM_COL+r)*BW +: BW];
         end
      end else begin : g_rect
         assign mat_tr = mat;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state  <= IDLE;
         cnt    <= '0;
         mat    <= RESET_MATRIX;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         mat    <= mat_next;
         done_q <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mat_next   = mat;
      done_next  = 1'b0;
      if (init) begin
         // Overrides everything, including a beat handshaking this cycle.
         mat_next   = INIT_MATRIX;
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               // Single-action priority chain; losers are dropped.
               if (load_start) begin
                  state_next = LOAD;
                  cnt_next   = '0;
               end else if (drain_start) begin
                  state_next = DRAIN;
                  cnt_next   = '0;
               end else if (all_wenable) begin
                  mat_next = all_wdata_list2d;
               end else if (transpose) begin
                  mat_next = mat_tr;
               end else if (shift_up) begin
                  mat_next = rows_up(mat, downmost_wenable ? downmost_wdata_list1d : INIT_ROW);
               end else if (shift_left) begin
                  mat_next = cols_left(mat, rightmost_wenable ? rightmost_wdata_list1d : INIT_COLUMN);
               end
            end
            LOAD: begin
               if (load_valid) begin
                  mat_next = rows_up(mat, load_data);
                  cnt_next = cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_ready) begin
                  mat_next = rows_up(mat, INIT_ROW);
                  cnt_next = cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign load_ready          = (state == LOAD);
   assign drain_valid         = (state == DRAIN);
   assign busy                = (state != IDLE);
   assign done                = done_q;
   assign all_rdata_list2d    = mat;
   assign upmost_rdata_list1d = mat[BW_ROW-1:0];
   assign drain_data          = mat[BW_ROW-1:0];

endmodule

// File: tb/tb_dca_matrix_register_type3.sv
// tb/tb_dca_matrix_register_type3.sv - self-checking bench for dca_matrix_register_type3
module tb_dca_matrix_register_type3;

   localparam int NR = 4;
   localparam int NC = 3;
   localparam int BW = 8;
   localparam int BR = NC*BW;
   localparam int BM = NR*BR;
   localparam logic [BM-1:0] M0     = 96'h0B0A09_080706_050403_020100;
   localparam logic [BM-1:0] ALL_5A = {12{8'h5A}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rstnn;
   logic           init, load_start, load_valid, drain_start, drain_ready;
   logic           all_wenable, transpose, shift_up, downmost_wenable, shift_left, rightmost_wenable;
   logic [BR-1:0]  load_data, downmost_wdata;
   logic [BM-1:0]  all_wdata;
   logic [NR*BW-1:0] rightmost_wdata;
   logic           load_ready, drain_valid, busy, done;
   logic [BR-1:0]  drain_data, upmost;
   logic [BM-1:0]  all_rdata;

   logic           s_all_wenable, s_transpose, s_shift_up;
   logic [71:0]    s_all_wdata, s_all_rdata;
   logic [23:0]    s_drain_data, s_upmost;
   logic           s_load_ready, s_drain_valid, s_busy, s_done;

   dca_matrix_register_type3 #(
      .NUM_ROW(NR), .NUM_COL(NC), .BW_TENSOR_SCALAR(BW),
      .RESET_VALUE(8'h00), .INIT_VALUE(8'h5A)
   ) dut (
      .clk(clk), .rstnn(rstnn), .init(init),
      .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .drain_start(drain_start), .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
      .all_wenable(all_wenable), .all_wdata_list2d(all_wdata),
      .shift_up(shift_up), .downmost_wenable(downmost_wenable), .downmost_wdata_list1d(downmost_wdata),
      .shift_left(shift_left), .rightmost_wenable(rightmost_wenable), .rightmost_wdata_list1d(rightmost_wdata),
      .transpose(transpose), .all_rdata_list2d(all_rdata), .upmost_rdata_list1d(upmost),
      .busy(busy), .done(done)
   );

   dca_matrix_register_type3 #(
      .NUM_ROW(3), .NUM_COL(3), .BW_TENSOR_SCALAR(BW),
      .RESET_VALUE(8'h00), .INIT_VALUE(8'h5A)
   ) dut_sq (
      .clk(clk), .rstnn(rstnn), .init(1'b0),
      .load_start(1'b0), .load_valid(1'b0), .load_ready(s_load_ready), .load_data(24'h0),
      .drain_start(1'b0), .drain_valid(s_drain_valid), .drain_ready(1'b0), .drain_data(s_drain_data),
      .all_wenable(s_all_wenable), .all_wdata_list2d(s_all_wdata),
      .shift_up(s_shift_up), .downmost_wenable(1'b0), .downmost_wdata_list1d(24'h0),
      .shift_left(1'b0), .rightmost_wenable(1'b0), .rightmost_wdata_list1d(24'h0),
      .transpose(s_transpose), .all_rdata_list2d(s_all_rdata), .upmost_rdata_list1d(s_upmost),
      .busy(s_busy), .done(s_done)
   );

   typedef struct packed {
      logic          init;
      logic          all_wen;
      logic          transpose;
      logic          shift_up;
      logic          down_wen;
      logic          shift_left;
      logic          right_wen;
      logic [BM-1:0] all_wdata;
      logic [BR-1:0] down_data;
      logic [NR*BW-1:0] right_data;
      logic [BM-1:0] exp_mat;
   } vec_t;

   vec_t          vecs [9];
   logic [BM-1:0] sb_mat [$];
   logic [BR-1:0] sb_row [$];
   logic [BR-1:0] rows [4];
   logic [BM-1:0] exp_m;
   logic [BR-1:0] exp_row;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_base;
   int cyc;
   logic ph;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(input string name, input logic [BM-1:0] act, input logic [BM-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic clear_inputs();
      init = 0; load_start = 0; load_valid = 0; drain_start = 0; drain_ready = 0;
      all_wenable = 0; transpose = 0; shift_up = 0; downmost_wenable = 0;
      shift_left = 0; rightmost_wenable = 0;
      load_data = '0; downmost_wdata = '0; all_wdata = '0; rightmost_wdata = '0;
      s_all_wenable = 0; s_transpose = 0; s_shift_up = 0; s_all_wdata = '0;
   endtask

   initial begin
      // init, all_wen, transpose, shift_up, down_wen, shift_left, right_wen, all_wdata, down_data, right_data, exp
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M0, 24'h0, 32'h0, M0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, M0, 24'h0, 32'hD3D2D1D0,
                  96'hD30B0A_D20807_D10504_D00201};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h0, 32'h0,
                  96'h5A5A5A_D30B0A_D20807_D10504};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 24'hC2C1C0, 32'h0,
                  96'hC2C1C0_5A5A5A_D30B0A_D20807};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 24'h0, 32'hFFFFFFFF,
                  96'h5AC2C1_5A5A5A_5AD30B_5AD208};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 24'h0, 32'h0,
                  96'h5AC2C1_5A5A5A_5AD30B_5AD208};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, M0, 24'h777777, 32'h99999999, M0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0, 24'h112233, 32'hFFFFFFFF,
                  96'h112233_0B0A09_080706_050403};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, M0, 24'h0, 32'h0, ALL_5A};
      rows[0] = 24'h030201; rows[1] = 24'h060504; rows[2] = 24'h090807; rows[3] = 24'h0C0B0A;

      clear_inputs();
      rstnn = 0;
      repeat (2) @(negedge clk);
      check("reset_matrix", all_rdata, '0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_load_ready", load_ready, 0);
      check("reset_drain_valid", drain_valid, 0);
      rstnn = 1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         init = vecs[i].init; all_wenable = vecs[i].all_wen; transpose = vecs[i].transpose;
         shift_up = vecs[i].shift_up; downmost_wenable = vecs[i].down_wen;
         shift_left = vecs[i].shift_left; rightmost_wenable = vecs[i].right_wen;
         all_wdata = vecs[i].all_wdata; downmost_wdata = vecs[i].down_data;
         rightmost_wdata = vecs[i].right_data;
         sb_mat.push_back(vecs[i].exp_mat);
         @(negedge clk);
         exp_m = sb_mat.pop_front();
         check($sformatf("vec%0d_matrix", i), all_rdata, exp_m);
         check($sformatf("vec%0d_upmost", i), upmost, exp_m[BR-1:0]);
         check($sformatf("vec%0d_busy", i), busy, 0);
         clear_inputs();
      end

      // Load with gaps between beats.
      load_start = 1;
      @(negedge clk);
      load_start = 0;
      check("load_ready_in_load", load_ready, 1);
      check("load_busy", busy, 1);
      done_base = done_cnt;
      for (int b = 0; b < 4; b++) begin
         load_valid = 0;
         @(negedge clk);
         check($sformatf("load_gap%0d_done", b), done, 0);
         load_valid = 1;
         load_data = rows[b];
         sb_row.push_back(rows[b]);
         @(negedge clk);
      end
      load_valid = 0;
      check("load_done_pulse", done, 1);
      check("load_busy_after", busy, 0);
      check("load_ready_after", load_ready, 0);
      @(negedge clk);
      check("load_done_single", done, 0);
      check("load_done_count", done_cnt - done_base, 1);
      check("load_matrix", all_rdata, 96'h0C0B0A_090807_060504_030201);
      check("load_row0", upmost, 24'h030201);

      // Drain with drain_ready toggling 1,0,1,...
      drain_start = 1;
      @(negedge clk);
      drain_start = 0;
      check("drain_valid_in_drain", drain_valid, 1);
      done_base = done_cnt;
      cyc = 0;
      ph = 1;
      while (sb_row.size() > 0 && cyc < 40) begin
         drain_ready = ph;
         if (ph && drain_valid) begin
            exp_row = sb_row.pop_front();
            check("drain_data", drain_data, exp_row);
         end
         ph = ~ph;
         cyc++;
         @(negedge clk);
      end
      drain_ready = 0;
      check("drain_beats_left", sb_row.size(), 0);
      check("drain_done_pulse", done, 1);
      check("drain_valid_after", drain_valid, 0);
      check("drain_busy_after", busy, 0);
      check("drain_matrix_init", all_rdata, ALL_5A);
      @(negedge clk);
      check("drain_done_count", done_cnt - done_base, 1);

      // Simultaneous starts (load wins), then init during the 3rd beat.
      load_start = 1;
      drain_start = 1;
      @(negedge clk);
      load_start = 0;
      drain_start = 0;
      check("both_start_load_ready", load_ready, 1);
      check("both_start_drain_valid", drain_valid, 0);
      load_valid = 1;
      load_data = 24'hAAAAAA;
      @(negedge clk);
      load_data = 24'hBBBBBB;
      @(negedge clk);
      done_base = done_cnt;
      init = 1;
      load_data = 24'hCCCCCC;
      @(negedge clk);
      init = 0;
      load_valid = 0;
      check("init_mid_load_matrix", all_rdata, ALL_5A);
      check("init_mid_load_busy", busy, 0);
      check("init_mid_load_ready", load_ready, 0);
      check("init_mid_load_done", done, 0);
      repeat (3) @(negedge clk);
      check("init_mid_load_no_done", done_cnt - done_base, 0);

      // Square transpose and its priority over shift_up.
      s_all_wenable = 1;
      s_all_wdata = 72'h080706_050403_020100;
      @(negedge clk);
      s_all_wenable = 0;
      check("sq_write", s_all_rdata, 72'h080706_050403_020100);
      s_transpose = 1;
      @(negedge clk);
      check("sq_transpose", s_all_rdata, 72'h080502_070401_060300);
      check("sq_transpose_row0", s_upmost, 24'h060300);
      s_shift_up = 1;
      @(negedge clk);
      s_transpose = 0;
      s_shift_up = 0;
      check("sq_transpose_over_shift", s_all_rdata, 72'h080706_050403_020100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dca_matrix_register_type3.md
Name: dca_matrix_register_type3

Overview:
- Generalised successor of the DCA square matrix register.
- Holds a NUM_ROW x NUM_COL matrix of scalars. Supports:
  - row-streamed load and drain over valid/ready handshakes, sequenced by an internal FSM;
  - whole-matrix write;
  - shift-up and shift-left with live downmost/rightmost fill;
  - transpose (square configurations only).
- Sits between DCA tensor DMA/row streams and the compute array, replacing hard-tied fill inputs with real ones.

Parameters:
- NUM_ROW, 4: matrix rows.
- NUM_COL, 4: matrix columns.
- BW_TENSOR_SCALAR, 32: bits per element.
- RESET_VALUE, 0: element value at reset.
- INIT_VALUE, RESET_VALUE: value used by init and by default shift fill.
- Derived widths:
  - BW_ROW = NUM_COL*BW_TENSOR_SCALAR.
  - BW_COLUMN = NUM_ROW*BW_TENSOR_SCALAR.
  - BW_MATRIX = NUM_ROW*BW_ROW.
- Element packing: element (r,c) occupies bits [(r*NUM_COL+c)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR]. Row r occupies [r*BW_ROW +: BW_ROW].

Ports:
- clk in 1: clock.
- rstnn in 1: reset, asynchronous, active-low.
- init in 1: fill all elements with INIT_VALUE, abort any stream.
- load_start in 1: begin row-stream load.
- load_valid in 1: load beat valid.
- load_ready out 1: load beat accepted when high with valid.
- load_data in BW_ROW: incoming row.
- drain_start in 1: begin row-stream drain.
- drain_valid out 1: drain row valid.
- drain_ready in 1: consumer ready.
- drain_data out BW_ROW: outgoing row (= row 0).
- all_wenable in 1: write whole matrix.
- all_wdata_list2d in BW_MATRIX: whole-matrix data.
- shift_up in 1: rows move up by one.
- downmost_wenable in 1: use downmost_wdata for the new bottom row.
- downmost_wdata_list1d in BW_ROW: bottom fill row.
- shift_left in 1: columns move left by one.
- rightmost_wenable in 1: use rightmost_wdata for the new right column.
- rightmost_wdata_list1d in BW_COLUMN: right fill column; element r at [r*BW +: BW].
- transpose in 1: transpose in place.
- all_rdata_list2d out BW_MATRIX: full matrix.
- upmost_rdata_list1d out BW_ROW: row 0.
- busy out 1: FSM not IDLE.
- done out 1: one-cycle pulse on load/drain completion.

Behaviour:
- Reset (rstnn low, async):
  - all elements = RESET_VALUE; state IDLE; beat counter 0.
  - load_ready = 0, drain_valid = 0, busy = 0, done = 0.
- All register updates occur on clk rising edge; outputs are registered-state-driven with no combinational path from inputs except load_ready/drain_valid, which decode state only.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE, priority per cycle:
  - init: all elements = INIT_VALUE.
  - else load_start: go LOAD, counter = 0.
  - else drain_start: go DRAIN, counter = 0.
  - else all_wenable: matrix = all_wdata.
  - else transpose: (r,c) <= (c,r). Only when NUM_ROW == NUM_COL; otherwise ignored, no state change.
  - else shift_up: row r <= row r+1; bottom row = downmost_wdata if downmost_wenable, else all INIT_VALUE.
  - else shift_left: (r,c) <= (r,c+1); column NUM_COL-1 element r = rightmost_wdata[r] if rightmost_wenable, else INIT_VALUE.
  - Lower-priority requests in the same cycle are dropped, not queued. load_start and drain_start together: load wins.
- LOAD:
  - load_ready = 1.
  - On load_valid & load_ready: shift up with bottom row = load_data; counter++.
  - On the NUM_ROW-th beat: go IDLE, done = 1 next cycle. After the load, row 0 holds the first beat.
- DRAIN:
  - drain_valid = 1, drain_data = row 0.
  - On drain_valid & drain_ready: shift up with INIT_VALUE fill; counter++.
  - On the NUM_ROW-th beat: go IDLE, done pulse.
- In LOAD/DRAIN, all_wenable/shift/transpose/start inputs are ignored.
- init in any state: elements = INIT_VALUE, go IDLE, counter 0, no done pulse. A beat presented in the same cycle is discarded.
- No back-pressure stall limit; the FSM waits indefinitely for handshakes.
- Counter width: clog2(NUM_ROW+1). Counter wraps only via return to IDLE.
- upmost_rdata_list1d and drain_data are always row 0 of current state.

Test Plan (NUM_ROW=4, NUM_COL=3, BW=8 unless stated):
1. Reset, then read -> all_rdata all RESET_VALUE; busy=0, done=0, load_ready=0, drain_valid=0.
2. Load with gaps:
   - Stimulus: load_start, then rows 0x030201, 0x060504, 0x090807, 0x0C0B0A with load_valid gaps between beats.
   - Required: done pulses exactly once, one cycle after the 4th beat; row0=0x030201, row3=0x0C0B0A; busy low after.
3. Drain under back-pressure:
   - Stimulus: drain the loaded matrix with drain_ready toggling 1,0,1.
   - Required: drain_data sequence 0x030201, 0x060504, 0x090807, 0x0C0B0A with no duplicates; final matrix all INIT_VALUE; done pulse.
4. Shifts on a matrix with (r,c)=r*3+c:
   - shift_left with rightmost_wenable=1, data {0xD3,0xD2,0xD1,0xD0} -> row0 = {0xD0,2,1}.
   - shift_up with downmost_wenable=0 -> row3 all INIT_VALUE.
5. Transpose and priority:
   - NUM_ROW=NUM_COL=3, (r,c)=r*3+c, transpose -> (0,1)=3, (2,0)=2.
   - transpose + shift_up in the same cycle -> only transpose applied.
   - Repeat transpose with 4x3 -> matrix unchanged.
6. init mid-load: init asserted after the 2nd load beat, together with load_valid -> matrix all INIT_VALUE, state IDLE, no done pulse, load_ready=0 next cycle.
